// File: rtl/calc_pkg.sv
// calc_pkg: shared definitions for the calculator sequencing controller.
//   state_t   - 4-bit controller state, value is exported on statedebug
//   KEY_*     - keypad codes for the operator and equals keys
//   OP_*      - OpSel codes driven to the arithmetic unit
//   is_digit  - key code 0-9
//   is_op     - key code A-D (add, sub, and, or)
//   op_code   - maps an operator key to its OpSel code
package calc_pkg;

  typedef enum logic [3:0] {
    CLR_A   = 4'd0,
    ENTER_A = 4'd1,
    LOAD_A  = 4'd2,
    CLR_B   = 4'd3,
    ENTER_B = 4'd4,
    LOAD_B  = 4'd5,
    LOAD_R  = 4'd6,
    SHOW_R  = 4'd7
  } state_t;

  localparam logic [3:0] KEY_ADD = 4'hA;
  localparam logic [3:0] KEY_SUB = 4'hB;
  localparam logic [3:0] KEY_AND = 4'hC;
  localparam logic [3:0] KEY_OR  = 4'hD;
  localparam logic [3:0] KEY_EQ  = 4'hF;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_AND = 2'd2;
  localparam logic [1:0] OP_OR  = 2'd3;

  function automatic logic is_digit(input logic [3:0] k);
    return (k <= 4'd9);
  endfunction

  function automatic logic is_op(input logic [3:0] k);
    return (k >= KEY_ADD) && (k <= KEY_OR);
  endfunction

  function automatic logic [1:0] op_code(input logic [3:0] k);
    logic [1:0] c;
    case (k)
      KEY_SUB: c = OP_SUB;
      KEY_AND: c = OP_AND;
      KEY_OR:  c = OP_OR;
      default: c = OP_ADD;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/calc_key_edge.sv
// calc_key_edge: key-press front end for calc_seq_ctrl.
// Optional build macro: CALC_KEY_SYNC_EN inserts a 2-flop synchronizer on
// trig and value ahead of the edge detector (adds 2 cycles of latency).
// Ports:
//   clock     - system clock
//   ClearAll  - synchronous active-high reset
//   trig      - key-press strobe from the keypad encoder
//   value     - 4-bit key code
//   key_ok    - one-cycle strobe on each 0->1 transition of (synchronized) trig
//   key_value - key code aligned with key_ok
module calc_key_edge (
  input  logic       clock,
  input  logic       ClearAll,
  input  logic       trig,
  input  logic [3:0] value,
  output logic       key_ok,
  output logic [3:0] key_value
);

  logic       trig_in;
  logic [3:0] val_in;
  logic       trig_q;

`ifdef CALC_KEY_SYNC_EN
  logic       trig_s1, trig_s2;
  logic [3:0] val_s1, val_s2;

  always_ff @(posedge clock) begin
    if (ClearAll) begin
      trig_s1 <= 1'b0;
      trig_s2 <= 1'b0;
      val_s1  <= 4'd0;
      val_s2  <= 4'd0;
    end else begin
      trig_s1 <= trig;
      trig_s2 <= trig_s1;
      val_s1  <= value;
      val_s2  <= val_s1;
    end
  end

  assign trig_in = trig_s2;
  assign val_in  = val_s2;
`else
  assign trig_in = trig;
  assign val_in  = value;
`endif

  // trig_q comes out of reset high so a key held through reset is not
  // mistaken for a fresh press.
  always_ff @(posedge clock) begin
    if (ClearAll) trig_q <= 1'b1;
    else          trig_q <= trig_in;
  end

  assign key_ok    = trig_in & ~trig_q;
  assign key_value = val_in;

endmodule

// File: rtl/calc_seq_ctrl.sv
// calc_seq_ctrl: control unit for the multi-digit four-function calculator.
// Sequences operand entry into the IU shift register, loads of A/B/R, the
// operation select and chaining of R back into A.
// Optional build macro: CALC_KEY_SYNC_EN (see calc_key_edge).
// Key strobe semantics: a key is offered when trig rises (key_ok for one
// cycle, value sampled in that cycle); there is no backpressure, keys that
// are meaningless in the current state are simply dropped.
// Ports:
//   clock, ClearAll (sync active-high reset), trig, value[3:0], ClearEntry
//   LoadA/LoadB/LoadR - active-low register load strobes
//   ASrcR             - A loads from R (chaining) instead of IU
//   ClrIU, ShiftIU    - IU clear and shift-in pulse
//   OpSel[OPW-1:0]    - latched operation (0 add, 1 sub, 2 and, 3 or)
//   IUAU              - display mux, 1 = AU/R
//   DigitCnt, Ovf     - digits in current operand, dropped-digit flag
//   statedebug[3:0]   - current state encoding
module calc_seq_ctrl
  import calc_pkg::*;
#(
  parameter int DIGITS = 2,
  parameter int OPW    = 2,
  parameter int CNT_W  = $clog2(DIGITS + 1)
) (
  input  logic             clock,
  input  logic             ClearAll,
  input  logic             trig,
  input  logic [3:0]       value,
  input  logic             ClearEntry,
  output logic             LoadA,
  output logic             LoadB,
  output logic             LoadR,
  output logic             ASrcR,
  output logic             ClrIU,
  output logic             ShiftIU,
  output logic [OPW-1:0]   OpSel,
  output logic             IUAU,
  output logic [CNT_W-1:0] DigitCnt,
  output logic             Ovf,
  output logic [3:0]       statedebug
);

  logic       key_ok;
  logic [3:0] key_value;

  calc_key_edge u_key_edge (
    .clock     (clock),
    .ClearAll  (ClearAll),
    .trig      (trig),
    .value     (value),
    .key_ok    (key_ok),
    .key_value (key_value)
  );

  state_t           state_q, state_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic             ovf_q, ovf_n;
  logic [OPW-1:0]   op_q, op_n;
  logic             shift_q, shift_n;
  logic             ce_q, ce_n;
  logic             chain_q, chain_n;
  logic             in_entry;
  logic             ce_hit;
  logic             key;

  always_ff @(posedge clock) begin
    if (ClearAll) begin
      state_q <= CLR_A;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      op_q    <= '0;
      shift_q <= 1'b0;
      ce_q    <= 1'b0;
      chain_q <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      ovf_q   <= ovf_n;
      op_q    <= op_n;
      shift_q <= shift_n;
      ce_q    <= ce_n;
      chain_q <= chain_n;
    end
  end

  always_comb begin
    state_n  = state_q;
    cnt_n    = cnt_q;
    ovf_n    = ovf_q;
    op_n     = op_q;
    shift_n  = 1'b0;
    ce_n     = 1'b0;
    chain_n  = 1'b0;
    in_entry = (state_q == ENTER_A) || (state_q == ENTER_B);
    // ClearEntry only acts while an operand is being typed; there it
    // swallows any key arriving in the same cycle.
    ce_hit   = ClearEntry && in_entry;
    key      = key_ok && !ce_hit;

    case (state_q)
      CLR_A: begin
        cnt_n   = '0;
        ovf_n   = 1'b0;
        state_n = ENTER_A;
      end
      ENTER_A, ENTER_B: begin
        if (ce_hit) begin
          cnt_n = '0;
          ovf_n = 1'b0;
          ce_n  = 1'b1;
        end else if (key) begin
          if (is_digit(key_value)) begin
            if (cnt_q < CNT_W'(DIGITS)) begin
              shift_n = 1'b1;
              cnt_n   = cnt_q + CNT_W'(1);
            end else begin
              ovf_n = 1'b1;
            end
          end else if ((state_q == ENTER_A) && is_op(key_value)) begin
            op_n    = OPW'(op_code(key_value));
            state_n = LOAD_A;
          end else if ((state_q == ENTER_B) && (key_value == KEY_EQ)) begin
            state_n = LOAD_B;
          end
        end
      end
      LOAD_A:  state_n = CLR_B;
      CLR_B: begin
        cnt_n   = '0;
        ovf_n   = 1'b0;
        state_n = ENTER_B;
      end
      LOAD_B:  state_n = LOAD_R;
      LOAD_R:  state_n = SHOW_R;
      SHOW_R: begin
        // An operator after a result chains R into A; chain_q marks the
        // single LOAD_A cycle that must select R as the A source.
        if (key && is_op(key_value)) begin
          op_n    = OPW'(op_code(key_value));
          chain_n = 1'b1;
          state_n = LOAD_A;
        end
      end
      default: state_n = CLR_A;
    endcase

    LoadA      = (state_q != LOAD_A);
    LoadB      = (state_q != LOAD_B);
    LoadR      = (state_q != LOAD_R);
    ClrIU      = (state_q == CLR_A) || (state_q == CLR_B) || ce_q;
    IUAU       = (state_q == LOAD_R) || (state_q == SHOW_R);
    ASrcR      = chain_q;
    ShiftIU    = shift_q;
    OpSel      = op_q;
    DigitCnt   = cnt_q;
    Ovf        = ovf_q;
    statedebug = state_q;
  end

endmodule

// File: tb/tb_calc_seq_ctrl.sv
module tb_calc_seq_ctrl;

`ifdef CALC_KEY_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic       clock = 1'b0;
  logic       ClearAll;
  logic       trig;
  logic [3:0] value;
  logic       ClearEntry;
  logic       LoadA, LoadB, LoadR, ASrcR, ClrIU, ShiftIU, IUAU, Ovf;
  logic [1:0] OpSel;
  logic [1:0] DigitCnt;
  logic [3:0] statedebug;

  int checks   = 0;
  int failures = 0;
  int shift_seen = 0;
  int s0;
  logic [1:0] exp_q[$];

  calc_seq_ctrl dut (
    .clock      (clock),
    .ClearAll   (ClearAll),
    .trig       (trig),
    .value      (value),
    .ClearEntry (ClearEntry),
    .LoadA      (LoadA),
    .LoadB      (LoadB),
    .LoadR      (LoadR),
    .ASrcR      (ASrcR),
    .ClrIU      (ClrIU),
    .ShiftIU    (ShiftIU),
    .OpSel      (OpSel),
    .IUAU       (IUAU),
    .DigitCnt   (DigitCnt),
    .Ovf        (Ovf),
    .statedebug (statedebug)
  );

  // clock / reset
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // scoreboard: every ShiftIU pulse must match the next expected DigitCnt
  always @(negedge clock) begin
    if (ShiftIU === 1'b1) begin
      shift_seen++;
      if (exp_q.size() == 0) check("shift_unexpected", ShiftIU, 0);
      else                   check("shift_cnt", DigitCnt, exp_q.pop_front());
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    ClearAll = 1'b1;
    trig = 1'b0;
    ClearEntry = 1'b0;
    value = 4'd0;
    step();
    step();
    ClearAll = 1'b0;
    step();
  endtask

  // raise trig and return once the response is visible
  task automatic press(input logic [3:0] k);
    trig  = 1'b1;
    value = k;
    repeat (LAT) step();
  endtask

  task automatic release_idle();
    trig = 1'b0;
    repeat (LAT + 1) step();
  endtask

  task automatic digit(input logic [3:0] k, input logic [1:0] exp_cnt);
    exp_q.push_back(exp_cnt);
    press(k);
    check("digit_shift", ShiftIU, 1);
    check("digit_cnt", DigitCnt, exp_cnt);
    step();
    check("digit_shift_off", ShiftIU, 0);
    release_idle();
  endtask

  initial begin
    ClearAll = 1'b1; trig = 1'b0; value = 4'd0; ClearEntry = 1'b0;

    // reset values
    step();
    step();
    check("rst_state", statedebug, 0);
    check("rst_loads", {LoadA, LoadB, LoadR}, 3'b111);
    check("rst_clriu", ClrIU, 1);
    check("rst_shift", ShiftIU, 0);
    check("rst_asrcr", ASrcR, 0);
    check("rst_opsel", OpSel, 0);
    check("rst_iuau", IUAU, 0);
    check("rst_cnt", DigitCnt, 0);
    check("rst_ovf", Ovf, 0);
    ClearAll = 1'b0;
    step();
    check("s1_enter_a", statedebug, 1);
    check("s1_clriu_off", ClrIU, 0);

    // scenario 1: 1 2 A 3 F
    digit(4'd1, 2'd1);
    digit(4'd2, 2'd2);
    press(4'hA);
    check("s1_load_a", statedebug, 2);
    check("s1_loada_low", LoadA, 0);
    check("s1_opsel_add", OpSel, 0);
    check("s1_asrcr", ASrcR, 0);
    step();
    check("s1_clr_b", statedebug, 3);
    check("s1_clr_b_clriu", ClrIU, 1);
    check("s1_loada_high", LoadA, 1);
    release_idle();
    check("s1_enter_b", statedebug, 4);
    check("s1_cnt_cleared", DigitCnt, 0);
    digit(4'd3, 2'd1);
    press(4'hF);
    check("s1_load_b", statedebug, 5);
    check("s1_loadb_low", LoadB, 0);
    step();
    check("s1_load_r", statedebug, 6);
    check("s1_loadr_low", LoadR, 0);
    check("s1_load_r_iuau", IUAU, 1);
    step();
    check("s1_show_r", statedebug, 7);
    check("s1_show_iuau", IUAU, 1);
    check("s1_loadr_high", LoadR, 1);
    release_idle();

    // scenario 2: overflow, then ClearEntry
    do_reset();
    s0 = shift_seen;
    digit(4'd4, 2'd1);
    digit(4'd5, 2'd2);
    press(4'd6);
    check("s2_drop_shift", ShiftIU, 0);
    check("s2_cnt_sat", DigitCnt, 2);
    check("s2_ovf", Ovf, 1);
    release_idle();
    check("s2_shift_count", shift_seen - s0, 2);
    ClearEntry = 1'b1;
    step();
    ClearEntry = 1'b0;
    check("s2_ce_clriu", ClrIU, 1);
    check("s2_ce_cnt", DigitCnt, 0);
    check("s2_ce_ovf", Ovf, 0);
    check("s2_ce_state", statedebug, 1);
    step();
    check("s2_ce_clriu_off", ClrIU, 0);

    // scenario 3: C with no digits, then chaining from SHOW_R
    press(4'hC);
    check("s3_load_a", statedebug, 2);
    check("s3_opsel_and", OpSel, 2);
    check("s3_no_chain", ASrcR, 0);
    release_idle();
    check("s3_enter_b", statedebug, 4);
    press(4'hF);
    check("s3_load_b_empty", LoadB, 0);
    release_idle();
    check("s3_show_r", statedebug, 7);
    press(4'd5);
    check("s3_digit_ignored", statedebug, 7);
    check("s3_digit_noshift", ShiftIU, 0);
    release_idle();
    press(4'hF);
    check("s3_eq_ignored", statedebug, 7);
    release_idle();
    press(4'hB);
    check("s3_chain_state", statedebug, 2);
    check("s3_chain_loada", LoadA, 0);
    check("s3_chain_asrcr", ASrcR, 1);
    check("s3_chain_opsel", OpSel, 1);
    step();
    check("s3_chain_clr_b", statedebug, 3);
    check("s3_chain_asrcr_off", ASrcR, 0);
    release_idle();
    press(4'hF);
    check("s3_f_load_b", LoadB, 0);
    step();
    check("s3_f_load_r", LoadR, 0);
    step();
    check("s3_f_show_r", statedebug, 7);
    release_idle();

    // scenario 4: long hold, then ClearEntry against a new edge
    do_reset();
    s0 = shift_seen;
    exp_q.push_back(2'd1);
    trig = 1'b1;
    value = 4'd7;
    repeat (20) step();
    check("s4_hold_one_shift", shift_seen - s0, 1);
    check("s4_hold_cnt", DigitCnt, 1);
    release_idle();
    s0 = shift_seen;
    ClearEntry = 1'b1;
    trig = 1'b1;
    value = 4'd8;
    step();
    check("s4_ce_clriu", ClrIU, 1);
    check("s4_ce_noshift", ShiftIU, 0);
    check("s4_ce_cnt", DigitCnt, 0);
    repeat (LAT - 1) step();
    ClearEntry = 1'b0;
    repeat (3) step();
    check("s4_ce_key_dropped", shift_seen - s0, 0);
    check("s4_ce_cnt_after", DigitCnt, 0);
    check("s4_ce_state", statedebug, 1);
    release_idle();

    // scenario 5: ClearAll during LOAD_R, trig held across release
    press(4'hC);
    check("s5_opsel_and", OpSel, 2);
    release_idle();
    press(4'hF);
    check("s5_load_b", statedebug, 5);
    step();
    check("s5_load_r", statedebug, 6);
    ClearAll = 1'b1;
    value = 4'd7;
    step();
    check("s5_rst_state", statedebug, 0);
    check("s5_rst_loads", {LoadA, LoadB, LoadR}, 3'b111);
    check("s5_rst_opsel", OpSel, 0);
    check("s5_rst_clriu", ClrIU, 1);
    check("s5_rst_iuau", IUAU, 0);
    s0 = shift_seen;
`ifdef CALC_KEY_SYNC_EN
    exp_q.push_back(2'd1);
`endif
    ClearAll = 1'b0;
    repeat (4) step();
    check("s5_post_state", statedebug, 1);
`ifndef CALC_KEY_SYNC_EN
    check("s5_held_no_key", shift_seen - s0, 0);
    check("s5_held_cnt", DigitCnt, 0);
`endif
    release_idle();

    check("exp_q_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/calc_seq_ctrl.md
Name: calc_seq_ctrl

Overview:
Parametrised successor to the two-function calculator control unit. Sequences multi-digit operand entry, a four-function operation select, result load and result chaining for the datapath: input unit (IU) shift register, A/B/R registers and arithmetic unit (AU). It sits between the keypad encoder and the datapath. It takes one key code per trig press and emits Moore-style load/clear strobes.

Parameters:
DIGITS, 2, max digits per operand; further digit keys are dropped and raise Ovf.
OPW, 2, width of OpSel; four ops are defined, and OPW must be >= 2.
CNT_W, $clog2(DIGITS+1), width of DigitCnt.

Ports:
clock  in  1  system clock; all state changes on posedge.
ClearAll  in  1  synchronous, active-high reset.
trig  in  1  key-press strobe; one key is accepted per 0->1 transition.
value  in  4  key code: 0-9 digit, A add, B sub, C and, D or, F equals; E ignored.
ClearEntry  in  1  synchronous, active-high; clears the operand currently being entered.
LoadA  out  1  active-low load strobe for register A.
LoadB  out  1  active-low load strobe for register B.
LoadR  out  1  active-low load strobe for register R.
ASrcR  out  1  1 = A loads from R (chaining); 0 = A loads from IU.
ClrIU  out  1  active-high IU clear.
ShiftIU  out  1  one-cycle pulse: IU shifts in value.
OpSel  out  OPW  latched op: 0 add, 1 sub, 2 and, 3 or.
IUAU  out  1  display mux: 1 = AU/R, 0 = IU.
DigitCnt  out  CNT_W  digits entered into the current operand.
Ovf  out  1  sticky per operand; set when a digit is dropped.
statedebug  out  4  current state encoding.

Behaviour:
- Key accept: key_ok = trig & ~trig_q, where trig_q is trig registered.
  - Holding trig high yields exactly one key.
  - value is sampled in the key_ok cycle; the response is visible after the next posedge.
- States (statedebug): CLR_A=0, ENTER_A=1, LOAD_A=2, CLR_B=3, ENTER_B=4, LOAD_B=5, LOAD_R=6, SHOW_R=7.
- Transitions:
  - CLR_A -> ENTER_A unconditionally.
  - ENTER_A:
    - digit key with DigitCnt<DIGITS -> ShiftIU pulse, DigitCnt+1.
    - digit key with DigitCnt==DIGITS -> dropped, Ovf=1.
    - op key A-D -> OpSel latched, then LOAD_A.
    - F/E -> ignored.
  - LOAD_A -> CLR_B.
  - CLR_B -> ENTER_B.
  - ENTER_B: digit handling identical to ENTER_A; F -> LOAD_B; op keys and E ignored.
  - LOAD_B -> LOAD_R -> SHOW_R.
  - SHOW_R:
    - op key -> OpSel latched, ASrcR=1 for one cycle in LOAD_A, then CLR_B (chaining).
    - digit or F -> ignored.
- Outputs per state (unlisted = inactive):
  - CLR_A, CLR_B: ClrIU=1.
  - LOAD_A: LoadA=0.
  - LOAD_B: LoadB=0.
  - LOAD_R: LoadR=0, IUAU=1.
  - SHOW_R: IUAU=1.
- ShiftIU is a registered one-cycle pulse, asserted the cycle after key_ok.
- Per-operand clears:
  - DigitCnt and Ovf clear in CLR_A/CLR_B and on an accepted ClearEntry.
  - LOAD_A entered directly from SHOW_R bypasses IU; DigitCnt is irrelevant there.
- ClearEntry:
  - In ENTER_A/ENTER_B: ClrIU=1 for one cycle, DigitCnt=0, Ovf=0, state unchanged.
  - In other states: ignored.
  - ClearEntry and key_ok in the same cycle: ClearEntry wins, key dropped.
- Reset values (ClearAll=1, including mid-operation):
  - Output/control values: state=CLR_A, LoadA=LoadB=LoadR=1, ClrIU=1 (clear applied during reset), ShiftIU=0, ASrcR=0, OpSel=0, IUAU=0, DigitCnt=0, Ovf=0.
  - Edge detector: trig_q is set to 1 in reset, so a key held through reset is not accepted.
- Priority: ClearAll > ClearEntry > key_ok.
- No illegal states: state 8-15 decode -> CLR_A on next edge.

Optional Feature:
CALC_KEY_SYNC_EN
- Defined: trig and value pass through a 2-flop synchronizer before edge detection.
  - Key-to-response latency grows by 2 cycles.
  - Synchronizer flops reset to 0; trig_q still resets to 1.
- Undefined: trig/value are treated as synchronous to clock; no extra latency.

Decomposition:
- Shared package calc_pkg:
  - state enum (4-bit, values above).
  - key code constants: KEY_ADD=4'hA, KEY_SUB=4'hB, KEY_AND=4'hC, KEY_OR=4'hD, KEY_EQ=4'hF.
  - OpSel codes.
  - is_digit function (value <= 9).
- One sub-module, calc_key_edge: optional synchronizer plus trig edge detector; outputs key_ok and sampled value.

Test Plan:
1. Reset, then press 1,2,A,3,F (each trig held 3 cycles).
   -> ShiftIU pulses twice; LoadA=0 one cycle, OpSel=0; ShiftIU once; LoadB=0 one cycle, then LoadR=0; SHOW_R with IUAU=1.
2. DIGITS=2: press 4,5,6 in ENTER_A.
   -> only 2 ShiftIU pulses; DigitCnt=2; Ovf=1.
   -> then ClearEntry=1 -> ClrIU=1 one cycle, DigitCnt=0, Ovf=0, still ENTER_A.
3. From SHOW_R press B.
   -> OpSel=1, LoadA=0 with ASrcR=1 in the same cycle, then CLR_B; F without digits still loads B and R.
4. trig held high 20 cycles with value=7.
   -> exactly one ShiftIU.
   -> ClearEntry and a new trig edge in the same cycle -> no ShiftIU, ClrIU=1.
5. ClearAll=1 during LOAD_R.
   -> next cycle state=CLR_A, all loads high, OpSel=0.
   -> trig held high across reset release -> no key accepted.
6. With CALC_KEY_SYNC_EN defined: repeat scenario 1.
   -> identical strobe sequence, each response delayed 2 cycles.
